// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit hex seven-segment driver: latches a hex word, scans the
// common anodes with a guard gap per slot, optional frame-synchronous update and LZ blanking.
module seg7_scan_driver #(
    parameter int N_DIGITS   = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int GUARD      = 16,
    parameter int ACTIVE_LOW = 1,
    parameter int FRAME_SYNC = 1,
    localparam int IDX_W     = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blank_mask,
    input  logic                  load,
    input  logic                  lz_en,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an,
    output logic [IDX_W-1:0]      digit_idx,
    output logic                  pending
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
    // XOR masks that turn active-high internal values into pin polarity.
    localparam logic [6:0]          SEG_POL  = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                DP_POL   = (ACTIVE_LOW != 0);
    localparam logic [N_DIGITS-1:0] AN_POL   = {N_DIGITS{ACTIVE_LOW != 0}};

    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic                  frame_start;
    logic                  in_guard;

    logic [4*N_DIGITS-1:0] shadow_value;
    logic [N_DIGITS-1:0]   shadow_dp;
    logic [N_DIGITS-1:0]   shadow_blank;

    logic [3:0]            nibbles [N_DIGITS];
    logic [N_DIGITS-1:0]   lz_dark;
    logic                  all_zero;
    logic                  dark;
    logic [6:0]            seg_ah;
    logic                  dp_ah;
    logic [N_DIGITS-1:0]   an_ah;

    function automatic logic [6:0] decode_hex(input logic [3:0] nib);
        case (nib)
            4'h0:    decode_hex = 7'h7E;
            4'h1:    decode_hex = 7'h30;
            4'h2:    decode_hex = 7'h6D;
            4'h3:    decode_hex = 7'h79;
            4'h4:    decode_hex = 7'h33;
            4'h5:    decode_hex = 7'h5B;
            4'h6:    decode_hex = 7'h5F;
            4'h7:    decode_hex = 7'h70;
            4'h8:    decode_hex = 7'h7F;
            4'h9:    decode_hex = 7'h7B;
            4'hA:    decode_hex = 7'h77;
            4'hB:    decode_hex = 7'h1F;
            4'hC:    decode_hex = 7'h4E;
            4'hD:    decode_hex = 7'h3D;
            4'hE:    decode_hex = 7'h4F;
            default: decode_hex = 7'h47;
        endcase
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign frame_start = (cnt == CNT_LAST) && (idx == IDX_LAST);

    if (GUARD == 0) begin : g_no_guard
        assign in_guard = 1'b0;
    end else begin : g_guard
        assign in_guard = (cnt < CNT_W'(GUARD));
    end

    if (FRAME_SYNC != 0) begin : g_frame_sync
        logic [4*N_DIGITS-1:0] stage_value;
        logic [N_DIGITS-1:0]   stage_dp;
        logic [N_DIGITS-1:0]   stage_blank;

        // A load on the frame-start edge lands in staging; the previous staging still commits.
        always_ff @(posedge clk) begin
            if (rst) begin
                stage_value  <= '0;
                stage_dp     <= '0;
                stage_blank  <= '0;
                shadow_value <= '0;
                shadow_dp    <= '0;
                shadow_blank <= '0;
                pending      <= 1'b0;
            end else begin
                if (frame_start) begin
                    shadow_value <= stage_value;
                    shadow_dp    <= stage_dp;
                    shadow_blank <= stage_blank;
                end
                if (load) begin
                    stage_value <= value;
                    stage_dp    <= dp_in;
                    stage_blank <= blank_mask;
                    pending     <= 1'b1;
                end else if (frame_start) begin
                    pending <= 1'b0;
                end
            end
        end
    end else begin : g_direct
        always_ff @(posedge clk) begin
            if (rst) begin
                shadow_value <= '0;
                shadow_dp    <= '0;
                shadow_blank <= '0;
            end else if (load) begin
                shadow_value <= value;
                shadow_dp    <= dp_in;
                shadow_blank <= blank_mask;
            end
        end
        assign pending = 1'b0;
    end

    always_comb begin
        for (int i = 0; i < N_DIGITS; i++) begin
            nibbles[i] = shadow_value[4*i +: 4];
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        all_zero = 1'b1;
        lz_dark  = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero & (nibbles[i] == 4'h0);
            if (i > 0) begin
                lz_dark[i] = lz_en & all_zero;
            end
        end
    end

    // Segments are also dark during the guard so nothing ghosts onto the next digit.
    always_comb begin
        an_ah  = '0;
        dark   = in_guard | shadow_blank[idx] | lz_dark[idx];
        seg_ah = dark ? 7'h00 : decode_hex(nibbles[idx]);
        dp_ah  = ~dark & shadow_dp[idx];
        if (!in_guard) begin
            an_ah[idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg       <= SEG_POL;
            dp        <= DP_POL;
            an        <= AN_POL;
            digit_idx <= '0;
        end else begin
            seg       <= seg_ah ^ SEG_POL;
            dp        <= dp_ah ^ DP_POL;
            an        <= an_ah ^ AN_POL;
            digit_idx <= idx;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: three configurations run in lockstep against
// a time-arithmetic reference model, with directed scenarios followed by random traffic.
module tb_seg7_scan_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  blank_mask;
    logic        load;
    logic        lz_en;

    logic [6:0] seg0, seg1, seg2;
    logic       dp0, dp1, dp2;
    logic [3:0] an0, an1;
    logic [0:0] an2;
    logic [1:0] idx0, idx1;
    logic [0:0] idx2;
    logic       pend0, pend1, pend2;

    seg7_scan_driver #(.N_DIGITS(4), .SCAN_DIV(8), .GUARD(1), .ACTIVE_LOW(0), .FRAME_SYNC(0)) dut0 (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .blank_mask(blank_mask),
        .load(load), .lz_en(lz_en), .seg(seg0), .dp(dp0), .an(an0), .digit_idx(idx0), .pending(pend0));

    seg7_scan_driver #(.N_DIGITS(4), .SCAN_DIV(8), .GUARD(1), .ACTIVE_LOW(0), .FRAME_SYNC(1)) dut1 (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .blank_mask(blank_mask),
        .load(load), .lz_en(lz_en), .seg(seg1), .dp(dp1), .an(an1), .digit_idx(idx1), .pending(pend1));

    seg7_scan_driver #(.N_DIGITS(1), .SCAN_DIV(4), .GUARD(1), .ACTIVE_LOW(1), .FRAME_SYNC(1)) dut2 (
        .clk(clk), .rst(rst), .value(value[3:0]), .dp_in(dp_in[0:0]), .blank_mask(blank_mask[0:0]),
        .load(load), .lz_en(lz_en), .seg(seg2), .dp(dp2), .an(an2), .digit_idx(idx2), .pending(pend2));

    logic [6:0] o_seg [3];
    logic       o_dp  [3];
    logic [3:0] o_an  [3];
    logic [1:0] o_idx [3];
    logic       o_pnd [3];
    assign o_seg[0] = seg0;  assign o_seg[1] = seg1;  assign o_seg[2] = seg2;
    assign o_dp[0]  = dp0;   assign o_dp[1]  = dp1;   assign o_dp[2]  = dp2;
    assign o_an[0]  = an0;   assign o_an[1]  = an1;   assign o_an[2]  = {3'b000, an2};
    assign o_idx[0] = idx0;  assign o_idx[1] = idx1;  assign o_idx[2] = {1'b0, idx2};
    assign o_pnd[0] = pend0; assign o_pnd[1] = pend1; assign o_pnd[2] = pend2;

    // Configuration table mirrored from the instance parameters above.
    int cfg_n  [3] = '{4, 4, 1};
    int cfg_sd [3] = '{8, 8, 4};
    int cfg_g  [3] = '{1, 1, 1};
    bit cfg_al [3] = '{1'b0, 1'b0, 1'b1};
    bit cfg_fs [3] = '{1'b0, 1'b1, 1'b1};

    logic [6:0] seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    // Model state: cycles since reset, displayed and staged words, pending flag.
    int         c     [3];
    logic [15:0] sv   [3];
    logic [3:0]  sdp  [3];
    logic [3:0]  sbl  [3];
    logic [15:0] stv  [3];
    logic [3:0]  stdp [3];
    logic [3:0]  stbl [3];
    bit          pend [3];

    logic [6:0] e_seg [3];
    logic       e_dp  [3];
    logic [3:0] e_an  [3];
    int         e_idx [3];
    bit         e_pnd [3];
    bit         e_lit [3];

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected pins after one edge, from time-since-reset arithmetic and the displayed word.
    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            int          n;
            int          cnt;
            int          idx;
            logic [15:0] vmask;
            logic [3:0]  dmask;
            logic [3:0]  nib;
            logic        guard;
            logic        dark;
            logic        fstart;
            logic [6:0]  sah;
            logic        dah;
            logic [3:0]  aah;
            n     = cfg_n[k];
            vmask = (n == 4) ? 16'hFFFF : 16'h000F;
            dmask = (n == 4) ? 4'hF : 4'h1;
            if (rst) begin
                c[k]    = 0;
                sv[k]   = '0; sdp[k]  = '0; sbl[k]  = '0;
                stv[k]  = '0; stdp[k] = '0; stbl[k] = '0;
                pend[k] = 1'b0;
                e_an[k]  = cfg_al[k] ? dmask : 4'h0;
                e_seg[k] = cfg_al[k] ? 7'h7F : 7'h00;
                e_dp[k]  = cfg_al[k];
                e_idx[k] = 0;
                e_lit[k] = 1'b0;
                e_pnd[k] = 1'b0;
            end else begin
                cnt   = c[k] % cfg_sd[k];
                idx   = (c[k] / cfg_sd[k]) % n;
                guard = (cnt < cfg_g[k]);
                nib   = 4'(sv[k] >> (4 * idx));
                dark  = guard || sbl[k][idx] || (lz_en && idx > 0 && (sv[k] >> (4 * idx)) == 16'h0);
                sah   = dark ? 7'h00 : seg_tab[nib];
                dah   = !dark && sdp[k][idx];
                aah   = guard ? 4'h0 : 4'(1 << idx);
                e_seg[k] = cfg_al[k] ? ~sah : sah;
                e_dp[k]  = cfg_al[k] ? ~dah : dah;
                e_an[k]  = cfg_al[k] ? (~aah & dmask) : aah;
                e_idx[k] = idx;
                e_lit[k] = !guard;
                fstart   = (cnt == cfg_sd[k] - 1) && (idx == n - 1);
                if (!cfg_fs[k]) begin
                    if (load) begin
                        sv[k] = value & vmask; sdp[k] = dp_in & dmask; sbl[k] = blank_mask & dmask;
                    end
                end else begin
                    if (fstart && pend[k]) begin
                        sv[k] = stv[k]; sdp[k] = stdp[k]; sbl[k] = stbl[k];
                    end
                    if (load) begin
                        stv[k] = value & vmask; stdp[k] = dp_in & dmask; stbl[k] = blank_mask & dmask;
                        pend[k] = 1'b1;
                    end else if (fstart) begin
                        pend[k] = 1'b0;
                    end
                end
                e_pnd[k] = pend[k];
                c[k]++;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("cfg%0d an", k), 32'(o_an[k]), 32'(e_an[k]));
            check($sformatf("cfg%0d digit_idx", k), 32'(o_idx[k]), 32'(e_idx[k]));
            check($sformatf("cfg%0d pending", k), 32'(o_pnd[k]), 32'(e_pnd[k]));
            if (e_lit[k] || rst) begin
                check($sformatf("cfg%0d seg", k), 32'(o_seg[k]), 32'(e_seg[k]));
                check($sformatf("cfg%0d dp", k), 32'(o_dp[k]), 32'(e_dp[k]));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b1; value = '0; dp_in = '0; blank_mask = '0; load = 1'b0; lz_en = 1'b0;
        repeat (3) tick();
        check("reset an0", 32'(an0), 32'h0);
        check("reset seg0", 32'(seg0), 32'h0);
        check("reset an2 active-low", 32'(an2), 32'h1);
        check("reset pend1", 32'(pend1), 32'h0);

        // Scan 3A0F: first lit anode two edges after release.
        rst = 1'b0; value = 16'h3A0F; load = 1'b1;
        tick();
        load = 1'b0;
        check("scan guard after release", 32'(an0), 32'h0);
        tick();
        check("scan first an", 32'(an0), 32'h1);
        check("scan first seg F", 32'(seg0), 32'h47);
        repeat (38) tick();

        // Frame sync: load in digit 2, reload in digit 3, commit at frame start.
        for (int i = 0; i < 64 && (c[1] % 32) != 19; i++) tick();
        value = 16'h1234; load = 1'b1;
        tick();
        load = 1'b0;
        check("fsync pending after load", 32'(pend1), 32'h1);
        for (int i = 0; i < 64 && (c[1] % 32) != 27; i++) tick();
        value = 16'h5678; load = 1'b1;
        tick();
        load = 1'b0;
        check("fsync pending after reload", 32'(pend1), 32'h1);
        for (int i = 0; i < 64 && (c[1] % 32) != 0; i++) tick();
        check("fsync pending cleared", 32'(pend1), 32'h0);
        repeat (2) tick();
        check("fsync digit0 shows 8", 32'(seg1), 32'h7F);
        check("fsync digit0 anode", 32'(an1), 32'h1);
        repeat (30) tick();

        // Leading-zero suppression and blanking.
        value = 16'h0050; lz_en = 1'b1; load = 1'b1;
        tick();
        load = 1'b0;
        repeat (70) tick();
        value = 16'h0000; load = 1'b1;
        tick();
        load = 1'b0;
        repeat (70) tick();
        blank_mask = 4'b0001; load = 1'b1;
        tick();
        load = 1'b0; blank_mask = 4'b0000;
        repeat (70) tick();

        // Polarity on the single-digit active-low instance.
        lz_en = 1'b0; value = 16'h0008; dp_in = 4'h1; load = 1'b1;
        tick();
        load = 1'b0;
        repeat (8) tick();
        for (int i = 0; i < 8 && (c[2] % 4) != 2; i++) tick();
        check("polarity seg 8", 32'(seg2), 32'h00);
        check("polarity dp", 32'(dp2), 32'h0);
        check("polarity an", 32'(an2), 32'h0);

        // Reset mid-scan with a simultaneous load.
        for (int i = 0; i < 64 && (c[0] % 32) != 13; i++) tick();
        value = 16'hFFFF; dp_in = 4'hF; load = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; load = 1'b0;
        check("midreset an0", 32'(an0), 32'h0);
        check("midreset pend1", 32'(pend1), 32'h0);
        repeat (40) tick();

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            load       = ($urandom % 6) == 0;
            value      = 16'($urandom) >> $urandom_range(0, 16);
            dp_in      = 4'($urandom);
            blank_mask = (($urandom % 4) == 0) ? 4'($urandom) : 4'h0;
            if (($urandom % 20) == 0) lz_en = ~lz_en;
            rst        = ($urandom % 200) == 0;
            tick();
        end
        rst = 1'b0; load = 1'b0;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
